line_even_odd_split: RTL and testbench

Streaming reorder stage that takes raster lines from the upstream Axis stream and emits each line with its even-indexed samples first, then its odd-indexed samples. This is the lazy-wavelet split that feeds the horizontal 1-D DWT lifting stage. Two line banks run ping-pong, so one line is written while the previous one is read out. Frame and line markers (sof/eol) travel with the data.

---
 rtl/line_even_odd_split_if.sv | 13 +
 rtl/line_even_odd_split.sv | 166 ++++++++++++++++
 tb/tb_line_even_odd_split.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_even_odd_split_if.sv
// Sample stream with frame/line markers: data plus sof/eol qualified by a valid/ready handshake.
interface line_even_odd_split_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sof;
  logic              eol;
  logic              ready;

  modport master (output data, valid, sof, eol, input ready);
  modport slave  (input data, valid, sof, eol, output ready);
endinterface

// File: rtl/line_even_odd_split.sv
// Lazy-wavelet line split: each raster line is re-emitted as its even samples followed by its
// odd samples, using two ping-pong line banks so writing and reading overlap.
module line_even_odd_split #(
  parameter int DATA_W   = 8,
  parameter int MAX_LINE = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  line_even_odd_split_if.slave  s,
  line_even_odd_split_if.master m,
  output logic                  err_ovf
);
  localparam int AW = $clog2(MAX_LINE);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_LINE);

  typedef enum logic [1:0] {RD_IDLE, RD_EVEN, RD_ODD} rd_state_t;

  // Stored line length: the eol sample counts unless the bank had already saturated.
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] cnt);
    if (cnt == MAX_LEN) return MAX_LEN;
    return cnt + LW'(1);
  endfunction

  logic [DATA_W-1:0] mem [0:2*MAX_LINE-1];

  logic          run;
  logic          wb;
  logic [LW-1:0] wcnt;
  logic          line_sof;
  logic [1:0]    bank_full;
  logic [LW-1:0] bank_len [0:1];
  logic [1:0]    bank_sof;

  logic accept;
  logic wr_en;
  logic first_sof;

  rd_state_t     rd_state;
  logic          rb;
  logic [LW-1:0] raddr;

  logic [LW-1:0] rd_addr_p0;
  logic [LW-1:0] cur_len;
  logic          rd_odd;
  logic          space;
  logic          issue_p0;
  logic          phase_last;
  logic          line_last;
  logic          sof_p0;
  logic          release_bank;

  logic [1:0]        ob_cnt;
  logic              ob_wp;
  logic              ob_rp;
  logic              pop;
  logic [DATA_W-1:0] ob_data_p1 [0:1];
  logic [1:0]        ob_sof_p1;
  logic [1:0]        ob_eol_p1;

  assign s.ready   = run && !bank_full[wb];
  assign accept    = s.valid && s.ready;
  assign wr_en     = accept && (wcnt != MAX_LEN);
  assign err_ovf   = accept && (wcnt == MAX_LEN);
  assign first_sof = (wcnt == '0) ? s.sof : line_sof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run         <= 1'b0;
      wb          <= 1'b0;
      wcnt        <= '0;
      line_sof    <= 1'b0;
      bank_full   <= 2'b00;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      bank_sof    <= 2'b00;
    end else begin
      run <= 1'b1;
      // Release and fill always address opposite banks, so both may land in one cycle.
      if (release_bank) bank_full[rb] <= 1'b0;
      if (accept) begin
        if (wcnt == '0) line_sof <= s.sof;
        if (s.eol) begin
          bank_full[wb] <= 1'b1;
          bank_len[wb]  <= sat_len(wcnt);
          bank_sof[wb]  <= first_sof;
          wb            <= ~wb;
          wcnt          <= '0;
        end else if (wcnt != MAX_LEN) begin
          wcnt <= wcnt + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb, wcnt[AW-1:0]}] <= s.data;
  end

  // p0: read issue; the IDLE cycle that finds a full bank already issues address 0.
  always_comb begin
    rd_addr_p0   = (rd_state == RD_IDLE) ? '0 : raddr;
    rd_odd       = (rd_state == RD_ODD);
    cur_len      = bank_len[rb];
    space        = (ob_cnt != 2'd2) || pop;
    issue_p0     = bank_full[rb] && space;
    phase_last   = ({1'b0, rd_addr_p0} + (LW+1)'(2)) >= {1'b0, cur_len};
    line_last    = phase_last && (rd_odd || (cur_len == LW'(1)));
    sof_p0       = bank_sof[rb] && !rd_odd && (rd_addr_p0 == '0);
    release_bank = issue_p0 && line_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      rb       <= 1'b0;
      raddr    <= '0;
    end else if (issue_p0) begin
      if (!phase_last) begin
        rd_state <= rd_odd ? RD_ODD : RD_EVEN;
        raddr    <= rd_addr_p0 + LW'(2);
      end else if (!line_last) begin
        rd_state <= RD_ODD;
        raddr    <= LW'(1);
      end else begin
        rd_state <= RD_IDLE;
        raddr    <= '0;
        rb       <= ~rb;
      end
    end
  end

  // p1: synchronous RAM read lands directly in a 2-entry output buffer slot.
  assign pop = (ob_cnt != 2'd0) && m.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_cnt <= 2'd0;
      ob_wp  <= 1'b0;
      ob_rp  <= 1'b0;
    end else begin
      if (issue_p0) ob_wp <= ~ob_wp;
      if (pop)      ob_rp <= ~ob_rp;
      unique case ({issue_p0, pop})
        2'b10:   ob_cnt <= ob_cnt + 2'd1;
        2'b01:   ob_cnt <= ob_cnt - 2'd1;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue_p0) begin
      ob_data_p1[ob_wp] <= mem[{rb, rd_addr_p0[AW-1:0]}];
      ob_sof_p1[ob_wp]  <= sof_p0;
      ob_eol_p1[ob_wp]  <= line_last;
    end
  end

  // Head slot only changes on a pop, so stalled outputs hold; empty buffer presents zeros.
  assign m.valid = (ob_cnt != 2'd0);
  assign m.data  = m.valid ? ob_data_p1[ob_rp] : '0;
  assign m.sof   = m.valid && ob_sof_p1[ob_rp];
  assign m.eol   = m.valid && ob_eol_p1[ob_rp];

endmodule

// File: tb/tb_line_even_odd_split.sv
// Directed bench for line_even_odd_split: reorder, degenerate lengths, back-to-back lines,
// random backpressure, overflow and asynchronous reset mid-line.
module tb_line_even_odd_split;
  localparam int DATA_W   = 8;
  localparam int MAX_LINE = 16;

  typedef logic [9:0] word_t;  // {eol, sof, data}

  logic clk = 1'b0;
  logic rst;
  logic err_ovf;

  always #5 clk = ~clk;

  line_even_odd_split_if #(.DATA_W(DATA_W)) s_if ();
  line_even_odd_split_if #(.DATA_W(DATA_W)) m_if ();

  line_even_odd_split #(.DATA_W(DATA_W), .MAX_LINE(MAX_LINE)) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (s_if),
    .m       (m_if),
    .err_ovf (err_ovf)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
  int    max_stall;
  int    eol_cyc;
  int    first_vld_cyc;
  bit    vld_seen;
  bit    prev_stall;
  word_t prev_word;
  word_t got_q[$];
  word_t exp_q[$];
  int    ovf_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_if.ready = 1'($urandom_range(0, 1));
        2:       m_if.ready = 1'b0;
        default: m_if.ready = 1'b1;
      endcase
    end
  end

  // Output monitor: records handshakes and overflow pulses, and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall)
        check_val("hold", {m_if.valid, m_if.eol, m_if.sof, m_if.data}, {1'b1, prev_word});
      if (m_if.valid && !vld_seen) begin
        vld_seen      = 1'b1;
        first_vld_cyc = cyc;
      end
      if (m_if.valid && m_if.ready) got_q.push_back({m_if.eol, m_if.sof, m_if.data});
      if (err_ovf) ovf_q.push_back(int'(s_if.data));
      prev_stall = m_if.valid && !m_if.ready;
      prev_word  = {m_if.eol, m_if.sof, m_if.data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_sample(input logic [7:0] d, input logic sof, input logic eol);
    int t;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.sof   = sof;
    s_if.eol   = eol;
    t = 0;
    @(negedge clk);
    while (!s_if.ready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (t > max_stall) max_stall = t;
    if (!s_if.ready) check_val("s_ready_tmo", 32'(s_if.ready), 32'd1);
    @(posedge clk);
    #1;
    if (eol) eol_cyc = cyc;
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
  endtask

  task automatic send_line(input int base, input int len, input bit sof);
    for (int i = 0; i < len; i++)
      send_sample(8'(base + i), sof && (i == 0), i == len - 1);
  endtask

  // Expected order for a line: evens then odds of the stored (possibly truncated) samples.
  task automatic gen_line(input int base, input int len, input bit sof);
    int    n;
    word_t last;
    n = (len > MAX_LINE) ? MAX_LINE : len;
    for (int i = 0; i < n; i += 2) exp_q.push_back({1'b0, sof && (i == 0), 8'(base + i)});
    for (int i = 1; i < n; i += 2) exp_q.push_back({2'b00, 8'(base + i)});
    last = exp_q.pop_back();
    exp_q.push_back(last | 10'h200);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check_val({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check_val(tag, 32'(got_q[i]), 32'(exp_q[i]));
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    ovf_q.delete();
    vld_seen  = 1'b0;
    max_stall = 0;
  endtask

  initial begin
    int sofs;
    rst        = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_m_valid", 32'(m_if.valid), 32'd0);
    check_val("rst_m_data",  32'(m_if.data),  32'd0);
    check_val("rst_m_sof",   32'(m_if.sof),   32'd0);
    check_val("rst_m_eol",   32'(m_if.eol),   32'd0);
    check_val("rst_err_ovf", 32'(err_ovf),    32'd0);
    check_val("rst_s_ready", 32'(s_if.ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("ready_after_rst", 32'(s_if.ready), 32'd1);

    start_test();
    exp_q = '{10'h100, 10'h002, 10'h004, 10'h006, 10'h001, 10'h003, 10'h005, 10'h207};
    send_line(0, 8, 1'b1);
    wait_drain("basic");
    check_val("latency", 32'(first_vld_cyc - eol_cyc), 32'd1);

    start_test();
    exp_q = '{10'h00a, 10'h00c, 10'h00e, 10'h00b, 10'h20d};
    send_line(10, 5, 1'b0);
    wait_drain("len5");

    start_test();
    exp_q = '{10'h355};
    send_line(8'h55, 1, 1'b1);
    wait_drain("len1");

    start_test();
    for (int l = 0; l < 4; l++) gen_line(l * 16, 16, l == 0);
    for (int l = 0; l < 4; l++) send_line(l * 16, 16, l == 0);
    wait_drain("b2b");
    sofs = 0;
    foreach (got_q[i]) if (got_q[i][8]) sofs++;
    check_val("b2b_sof_once", 32'(sofs), 32'd1);
    check_val("b2b_stall_le2", 32'(max_stall <= 2), 32'd1);
    check_val("b2b_no_ovf", 32'(ovf_q.size()), 32'd0);

    start_test();
    ready_mode = 1;
    for (int l = 0; l < 3; l++) gen_line(l * 13, 13, l == 0);
    for (int l = 0; l < 3; l++) send_line(l * 13, 13, l == 0);
    wait_drain("bp");
    ready_mode = 0;

    start_test();
    exp_q = '{10'h100, 10'h002, 10'h004, 10'h006, 10'h008, 10'h00a, 10'h00c, 10'h00e,
              10'h001, 10'h003, 10'h005, 10'h007, 10'h009, 10'h00b, 10'h00d, 10'h20f,
              10'h028, 10'h02a, 10'h029, 10'h22b};
    send_line(0, 18, 1'b1);
    send_line(40, 4, 1'b0);
    wait_drain("ovf");
    check_val("ovf_cnt", 32'(ovf_q.size()), 32'd2);
    if (ovf_q.size() == 2) begin
      check_val("ovf_s16", 32'(ovf_q[0]), 32'd16);
      check_val("ovf_s17", 32'(ovf_q[1]), 32'd17);
    end

    start_test();
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_line(8'h60, 4, 1'b1);
    send_sample(8'h70, 1'b0, 1'b0);
    send_sample(8'h71, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_valid", 32'(m_if.valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(m_if.valid), 32'd0);
    check_val("mid_rst_data",  32'(m_if.data),  32'd0);
    check_val("mid_rst_sof",   32'(m_if.sof),   32'd0);
    check_val("mid_rst_eol",   32'(m_if.eol),   32'd0);
    check_val("mid_rst_ready", 32'(s_if.ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    start_test();
    exp_q = '{10'h100, 10'h002, 10'h001, 10'h203};
    send_line(0, 4, 1'b1);
    wait_drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
